instruction_encoder: RTL
========================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have ports `clk` (in, 1, rising-edge clock) and `rst_n` (in, 1, reset); the design uses one clock, and reset is asynchronous and active-low.
REQ-002 SHALL have ports `in_valid` (in, 1) and `in_ready` (out, 1): request handshake.
REQ-003 SHALL have ports `imm_type` (in, 3) and `imm` (in, 64): `imm_type` values 000=I, 001=S, 010=B, 011=U, 100=J, 101=LI (load constant); `imm` is the signed immediate.
REQ-004 SHALL have ports `rd`, `rs1`, `rs2` (in, 5 each), `funct3` (in, 3) and `opcode` (in, 7): non-immediate fields.
REQ-005 SHALL have ports `out_valid` (in/out: out, 1), `out_ready` (in, 1), `instruction` (out, 32) and `range_err` (out, 1).

Function
REQ-006 SHALL take a request on a clk edge when `in_valid` && `in_ready`, and SHALL assert `in_ready` only in IDLE.
REQ-007 SHALL have FSM states IDLE, EMIT, EMIT_HI and EMIT_LO; an accepted request goes from IDLE to EMIT, or for LI to EMIT_HI, at the accepting edge.
REQ-008 SHALL show the first `out_valid` 1 cycle after acceptance, with outputs registered.
REQ-009 SHALL hold `instruction` and `range_err` stable while `out_valid` && !`out_ready`; a beat completes on an edge with `out_valid` && `out_ready`.
REQ-010 SHALL leave EMIT for IDLE on completion, leave EMIT_HI for EMIT_LO on completion, and leave EMIT_LO for IDLE on completion.
REQ-011 SHALL pack I type as `imm[11:0]`->[31:20] plus `rs1`, `funct3`, `rd`, `opcode`; legal only if `imm` equals the sign-extension of `imm[11:0]`.
REQ-012 SHALL pack S type as `imm[11:5]`->[31:25] and `imm[4:0]`->[11:7] plus `rs2`, `rs1`, `funct3`, `opcode`; it uses the same 12-bit range rule as I type.
REQ-013 SHALL pack B type as `imm[12]`,`imm[10:5]`->[31:25] and `imm[4:1]`,`imm[11]`->[11:7]; legal only if `imm[0]`==0 and `imm` is a 13-bit signed value.
REQ-014 SHALL pack U type as `imm[31:12]`->[31:12] plus `rd`, `opcode`; legal only if `imm[11:0]`==0 and `imm` is a 32-bit signed value.
REQ-015 SHALL pack J type as `imm[20|10:1|11|19:12]`->[31:12] plus `rd`, `opcode`; legal only if `imm[0]`==0 and `imm` is a 21-bit signed value.
REQ-016 SHALL handle LI by ignoring `opcode`, `funct3`, `rs1` and `rs2`, setting lo=`imm[11:0]` and hi=`imm[31:12]`+`imm[11]` (20-bit), then emitting LUI `rd`,hi (opcode 0110111) followed by ADDI `rd`,`rd`,lo (opcode 0010011, funct3 000).
REQ-017 SHALL treat LI as legal only if `imm` is 32-bit signed and not in 0x7FFFF800..0x7FFFFFFF (the range where hi wraps).
REQ-018 SHALL make an illegal immediate or `imm_type` 110/111 produce one EMIT beat with `instruction`=0 and `range_err`=1; an illegal LI also goes to EMIT, not EMIT_HI.
REQ-019 SHALL drive `range_err`=0 on every legal beat.

Reset
REQ-020 SHALL make `rst_n` low force, asynchronously, the state to IDLE, `out_valid`=0, `instruction`=0, `range_err`=0 and `in_ready`=1.
REQ-021 SHALL, on reset mid-operation (including between LUI and ADDI), discard the pending beat; no ADDI is emitted after release.

Configuration
REQ-022 SHALL support macro `LI_SHORT_EN`; when defined, an LI with `imm` in the 12-bit signed range emits only ADDI `rd`,x0,`imm` (EMIT).
REQ-023 SHALL, when `LI_SHORT_EN` is defined, make an LI with lo==0 emit only LUI `rd`,hi.
REQ-024 SHALL, when `LI_SHORT_EN` is not defined, make every legal LI emit exactly 2 beats.

Verification
REQ-025 SHALL cover I type: `imm`=-1, `rd`=1, `rs1`=0, `funct3`=000, `opcode`=0010011 -> `instruction`=0xFFF00093, `range_err`=0, 1 cycle latency.
REQ-026 SHALL cover B type: `imm`=-4, `rs1`=1, `rs2`=2, `funct3`=000, `opcode`=1100011 -> 0xFE208EE3; the same request with `imm`=3 -> `instruction`=0, `range_err`=1.
REQ-027 SHALL cover LI: `imm`=0x12345FFF, `rd`=5, `out_ready` low 3 cycles -> 0x123462B7 held stable, then 0xFFF28293; `in_ready` low until the second beat completes.
REQ-028 SHALL cover the LI boundary: `imm`=0x7FFFF800 -> single beat, `instruction`=0, `range_err`=1.
REQ-029 SHALL cover reset mid-LI: `rst_n` pulsed low after the LUI beat completes -> `out_valid`=0, no ADDI beat, and `in_ready`=1 after release.
REQ-030 SHALL cover LI with `imm`=-1, `rd`=1: with `LI_SHORT_EN` -> a single 0xFFF00093; without it -> 0x000000B7 then 0xFFF08093.

Source files
------------

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs an immediate plus register fields into one RV32 instruction word,
// or into a LUI/ADDI pair for a load-constant (LI) request.
// Optional feature macro: LI_SHORT_EN (single-beat LI when one instruction suffices).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (ready only when idle)
//   imm_type, imm         immediate format (I,S,B,U,J,LI) and signed 64-bit immediate
//   rd, rs1, rs2, funct3, opcode  non-immediate instruction fields
//   out_valid / out_ready output beat handshake
//   instruction, range_err encoded word, and flag for an unencodable request
module instruction_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_type,
    input  logic [63:0] imm,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  opcode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instruction,
    output logic        range_err
);
    typedef enum logic [1:0] {IDLE, EMIT, EMIT_HI, EMIT_LO} state_t;
    state_t state, next_state;
    logic [31:0] enc, lui, addi, pend_q;
    logic [19:0] hi;
    logic        err, two, fit12, fit13, fit21, fit32, li_ok;
    // an immediate fits n signed bits when bits [63:n-1] are all equal
    assign fit12 = (&imm[63:11]) | ~(|imm[63:11]);
    assign fit13 = (&imm[63:12]) | ~(|imm[63:12]);
    assign fit21 = (&imm[63:20]) | ~(|imm[63:20]);
    assign fit32 = (&imm[63:31]) | ~(|imm[63:31]);
    // ADDI sign-extends lo, so hi rounds up when imm[11] is set; at the top of the
    // positive range that rounding would wrap hi to a negative value
    assign hi    = imm[31:12] + {19'd0, imm[11]};
    assign li_ok = fit32 & (imm[31:11] != 21'h0FFFFF);
    assign lui   = {hi, rd, 7'b0110111};
    assign addi  = {imm[11:0], rd, 3'b000, rd, 7'b0010011};
    always_comb begin
        enc = '0;
        err = 1'b1;
        two = 1'b0;
        case (imm_type)
            3'd0: begin
                err = ~fit12;
                enc = {imm[11:0], rs1, funct3, rd, opcode};
            end
            3'd1: begin
                err = ~fit12;
                enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            end
            3'd2: begin
                err = imm[0] | ~fit13;
                enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            end
            3'd3: begin
                err = (|imm[11:0]) | ~fit32;
                enc = {imm[31:12], rd, opcode};
            end
            3'd4: begin
                err = imm[0] | ~fit21;
                enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            end
            3'd5: begin
                err = ~li_ok;
`ifdef LI_SHORT_EN
                enc = fit12 ? {imm[11:0], 5'd0, 3'b000, rd, 7'b0010011} : lui;
                two = ~fit12 & (|imm[11:0]);
`else
                enc = lui;
                two = 1'b1;
`endif
            end
            default: ;
        endcase
        if (err) begin
            enc = '0;
            two = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = in_valid ? (two ? EMIT_HI : EMIT) : IDLE;
            EMIT:    next_state = out_ready ? IDLE : EMIT;
            EMIT_HI: next_state = out_ready ? EMIT_LO : EMIT_HI;
            EMIT_LO: next_state = out_ready ? IDLE : EMIT_LO;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state != IDLE;
    end
    // the ADDI half of an LI is captured at acceptance and swapped in after the LUI beat
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            instruction <= '0;
            range_err   <= 1'b0;
            pend_q      <= '0;
        end else if (in_valid && in_ready) begin
            instruction <= enc;
            range_err   <= err;
            pend_q      <= addi;
        end else if (state == EMIT_HI && out_ready) begin
            instruction <= pend_q;
        end
endmodule
